// File: rtl/lsu_if.sv
// LSU bus bundle: EXU->LSU instruction bus, memory read response and
// the LSU->WBU result bus. The slave modport is the LSU's view; the master
// modport is the surrounding pipeline/memory view.
interface lsu_if;
    localparam int EXU_LSU_BUS_WIDTH = 193;
    localparam int LSU_WBU_BUS_WIDTH = 184;

    logic                         exu_valid_i;
    logic [EXU_LSU_BUS_WIDTH-1:0] exu_lsu_bus_i;
    logic                         lsu_ready_o;
    logic [31:0]                  mem_rdata_i;
    logic                         mem_rvalid_i;
    logic                         lsu_valid_o;
    logic                         wbu_ready_i;
    logic [LSU_WBU_BUS_WIDTH-1:0] lsu_wbu_bus_o;

    modport slave (
        input  exu_valid_i, exu_lsu_bus_i, mem_rdata_i, mem_rvalid_i, wbu_ready_i,
        output lsu_ready_o, lsu_valid_o, lsu_wbu_bus_o
    );

    modport master (
        output exu_valid_i, exu_lsu_bus_i, mem_rdata_i, mem_rvalid_i, wbu_ready_i,
        input  lsu_ready_o, lsu_valid_o, lsu_wbu_bus_o
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit stage: latches one EXU instruction, waits for read data
// on loads, aligns/extends it, selects rd_wdata and holds a registered WBU
// bus under valid/ready. Optional load-response timeout is enabled by
// defining LSU_TIMEOUT_EN.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    lsu_if.slave bus
);
    typedef struct packed {
        logic [31:0] csr_wdata;
        logic        res_from_compare;
        logic        compare_result;
        logic [31:0] snpc;
        logic        csr_we;
        logic [1:0]  mem_addr_mask;
        logic [3:0]  mem_re;
        logic [11:0] csr_addr;
        logic [31:0] alu_result;
        logic [31:0] csr_value;
        logic        res_from_mem;
        logic        res_from_csr;
        logic        gr_we;
        logic [4:0]  rd;
        logic        excp_flush;
        logic        xret_flush;
        logic        break_signal;
        logic        jmp_flag;
        logic [31:0] jmp_target;
    } exu_bus_t;

    typedef struct packed {
        logic [31:0] csr_wdata;
        logic [31:0] snpc;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic [31:0] csr_value;
        logic        gr_we;
        logic [4:0]  rd;
        logic [31:0] rd_wdata;
        logic        excp_flush;
        logic        xret_flush;
        logic        break_signal;
        logic        jmp_flag;
        logic [31:0] jmp_target;
        logic        lsu_fault;
    } wbu_bus_t;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, RESP} state_t;

    state_t   state_reg, state_next;
    exu_bus_t in_reg;
    exu_bus_t in_cur;
    wbu_bus_t out_reg, out_next;
    logic     accept;

    // Pick the addressed lane of the read word and extend it to 32 bits.
    function automatic logic [31:0] align_load(input logic [3:0] mem_re,
                                               input logic [1:0] mask,
                                               input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = rdata[{mask, 3'b000} +: 8];
        half_v = rdata[{mask[1], 4'b0000} +: 16];
        case (mem_re)
            4'b0001: align_load = {{24{byte_v[7]}}, byte_v};
            4'b1001: align_load = {24'b0, byte_v};
            4'b0011: align_load = {{16{half_v[15]}}, half_v};
            4'b1011: align_load = {16'b0, half_v};
            default: align_load = rdata;
        endcase
    endfunction

    // Build the WBU bus from latched fields; a fault squashes the write-back.
    function automatic wbu_bus_t make_out(input exu_bus_t f,
                                          input logic [31:0] load_data,
                                          input logic fault);
        wbu_bus_t o;
        o.csr_wdata    = f.csr_wdata;
        o.snpc         = f.snpc;
        o.csr_we       = f.csr_we;
        o.csr_addr     = f.csr_addr;
        o.csr_value    = f.csr_value;
        o.gr_we        = f.gr_we;
        o.rd           = f.rd;
        o.excp_flush   = f.excp_flush;
        o.xret_flush   = f.xret_flush;
        o.break_signal = f.break_signal;
        o.jmp_flag     = f.jmp_flag;
        o.jmp_target   = f.jmp_target;
        o.lsu_fault    = 1'b0;
        if (f.res_from_mem)
            o.rd_wdata = load_data;
        else if (f.res_from_csr)
            o.rd_wdata = f.csr_value;
        else if (f.res_from_compare)
            o.rd_wdata = {31'b0, f.compare_result};
        else
            o.rd_wdata = f.alu_result;
        if (fault) begin
            o.lsu_fault  = 1'b1;
            o.excp_flush = 1'b1;
            o.gr_we      = 1'b0;
            o.rd_wdata   = 32'b0;
        end
        return o;
    endfunction

    assign in_cur            = bus.exu_lsu_bus_i;
    assign accept            = (state_reg == IDLE) && bus.exu_valid_i;
    assign bus.lsu_ready_o   = (state_reg == IDLE) && !rst_i;
    assign bus.lsu_valid_o   = (state_reg == RESP);
    assign bus.lsu_wbu_bus_o = out_reg;

`ifdef LSU_TIMEOUT_EN
    logic [15:0] cnt_reg, cnt_next;
    logic        timeout_hit;

    assign timeout_hit = (cnt_reg == 16'(TIMEOUT_CYCLES - 1));
    // Counts WAIT_MEM cycles; held at zero in every other state so entry starts clean.
    always_comb begin
        cnt_next = 16'b0;
        if (state_reg == WAIT_MEM)
            cnt_next = cnt_reg + 16'd1;
    end

    // Timeout counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_reg <= 16'b0;
        else
            cnt_reg <= cnt_next;
    end
`endif

    // Next-state and next-output selection.
    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        case (state_reg)
            IDLE: begin
                if (bus.exu_valid_i) begin
                    if (in_cur.mem_re != 4'b0) begin
                        state_next = WAIT_MEM;
                    end else begin
                        state_next = RESP;
                        out_next   = make_out(in_cur, 32'b0, 1'b0);
                    end
                end
            end
            WAIT_MEM: begin
                if (bus.mem_rvalid_i) begin
                    state_next = RESP;
                    out_next   = make_out(in_reg,
                                          align_load(in_reg.mem_re, in_reg.mem_addr_mask,
                                                     bus.mem_rdata_i),
                                          1'b0);
                end
`ifdef LSU_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = RESP;
                    out_next   = make_out(in_reg, 32'b0, 1'b1);
                end
`endif
            end
            RESP: begin
                if (bus.wbu_ready_i)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched instruction and registered WBU bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            out_reg   <= '0;
            in_reg    <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            if (accept)
                in_reg <= in_cur;
        end
    end
endmodule
